// File: rtl/pong_pkg.sv
// pong_pkg
//   Geometry and timing defaults shared by paddle control, the ball engine
//   and the pixel renderer, plus the ball-engine FSM state type.
//   No ports (package).
package pong_pkg;

    localparam int DEF_SCREEN_WIDTH  = 640;
    localparam int DEF_SCREEN_HEIGHT = 480;
    localparam int DEF_BALL_SIZE     = 8;
    localparam int DEF_PADDLE_HEIGHT = 60;
    localparam int DEF_PADDLE_WIDTH  = 10;
    localparam int DEF_PADDLE1_X     = 20;
    localparam int DEF_PADDLE2_X     = 610;
    localparam int DEF_BALL_SPEED    = 2;
    localparam int DEF_TICK_DIV      = 400_000;
    localparam int DEF_SERVE_TICKS   = 60;
    localparam int DEF_MAX_SCORE     = 9;

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_POINT = 2'd2,
        ST_OVER  = 2'd3
    } ball_state_t;

    // Score increment that sticks at the limit.
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider
//   Free-running divider producing a registered one-cycle tick every DIV
//   enabled clock cycles. The count holds while en is low.
//   Ports: clk, reset_n (async active-low), en (count enable),
//          tick (one-cycle pulse, registered, in the cycle after the wrap).
module tick_divider #(
    parameter int DIV = 400_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= en && (cnt == LAST);
            if (en) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine
//   Ball motion, wall/paddle bounces, miss detection and scoring.
//   Ports: clk, reset_n (async active-low), game_en (freezes everything
//          when low), paddle1_y/paddle2_y (paddle tops), ball_x/ball_y
//          (ball top-left), score1/score2, point_p1/point_p2 (one-cycle
//          scoring pulses), game_over, state_dbg (current FSM state).
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int BALL_SIZE     = DEF_BALL_SIZE,
    parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
    parameter int PADDLE_WIDTH  = DEF_PADDLE_WIDTH,
    parameter int PADDLE1_X     = DEF_PADDLE1_X,
    parameter int PADDLE2_X     = DEF_PADDLE2_X,
    parameter int BALL_SPEED    = DEF_BALL_SPEED,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int SERVE_TICKS   = DEF_SERVE_TICKS,
    parameter int MAX_SCORE     = DEF_MAX_SCORE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        game_en,
    input  logic [9:0]  paddle1_y,
    input  logic [9:0]  paddle2_y,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  score1,
    output logic [3:0]  score2,
    output logic        point_p1,
    output logic        point_p2,
    output logic        game_over,
    output ball_state_t state_dbg
);

    // Comparisons are done in 11 bits so sums like y+SIZE+SPEED never wrap.
    localparam logic [10:0] W   = 11'(SCREEN_WIDTH);
    localparam logic [10:0] H   = 11'(SCREEN_HEIGHT);
    localparam logic [10:0] SZ  = 11'(BALL_SIZE);
    localparam logic [10:0] SPD = 11'(BALL_SPEED);
    localparam logic [10:0] PH  = 11'(PADDLE_HEIGHT);
    localparam logic [10:0] P1E = 11'(PADDLE1_X + PADDLE_WIDTH);
    localparam logic [10:0] P2X = 11'(PADDLE2_X);
    localparam logic [9:0]  CX  = 10'((SCREEN_WIDTH - BALL_SIZE) / 2);
    localparam logic [9:0]  CY  = 10'((SCREEN_HEIGHT - BALL_SIZE) / 2);
    localparam logic [3:0]  MAXS = 4'(MAX_SCORE);
    localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
    localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);

    ball_state_t   state, state_nxt;
    logic          tick, tick_en;
    logic          dx, dy, serve_dy;
    logic [SW-1:0] serve_cnt;

    logic [10:0] bx, by, p1y, p2y;
    logic [9:0]  x_nxt, y_nxt;
    logic        dx_nxt, dy_nxt;
    logic        ovl1, ovl2, hit1, hit2, miss1, miss2;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (game_en),
        .tick    (tick)
    );

    // A tick already registered when game_en drops must not move the ball.
    assign tick_en = tick && game_en;

    assign bx  = {1'b0, ball_x};
    assign by  = {1'b0, ball_y};
    assign p1y = {1'b0, paddle1_y};
    assign p2y = {1'b0, paddle2_y};

    // Candidate motion for the next tick; both axes are evaluated
    // independently so a wall and a paddle can bounce on the same tick.
    always_comb begin
        y_nxt  = ball_y;
        dy_nxt = dy;
        if (dy) begin
            if (by + SZ + SPD >= H) begin
                y_nxt  = 10'(H - SZ);
                dy_nxt = 1'b0;
            end else begin
                y_nxt = 10'(by + SPD);
            end
        end else begin
            if (by <= SPD) begin
                y_nxt  = '0;
                dy_nxt = 1'b1;
            end else begin
                y_nxt = 10'(by - SPD);
            end
        end

        ovl1  = (by + SZ > p1y) && (by < p1y + PH);
        ovl2  = (by + SZ > p2y) && (by < p2y + PH);
        // x-SPEED <= edge is rewritten as x <= edge+SPEED to avoid underflow.
        hit1  = !dx && (bx >= P1E) && (bx <= P1E + SPD) && ovl1;
        hit2  = dx && (bx + SZ <= P2X) && (bx + SZ + SPD >= P2X) && ovl2;
        miss1 = !dx && !hit1 && (bx <= SPD);
        miss2 = dx && !hit2 && (bx + SZ + SPD >= W);

        x_nxt  = ball_x;
        dx_nxt = dx;
        if (hit1) begin
            x_nxt  = 10'(P1E);
            dx_nxt = 1'b1;
        end else if (hit2) begin
            x_nxt  = 10'(P2X - SZ);
            dx_nxt = 1'b0;
        end else if (dx) begin
            x_nxt = 10'(bx + SPD);
        end else begin
            x_nxt = 10'(bx - SPD);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_SERVE;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SERVE: if (tick_en && serve_cnt == SERVE_LAST) state_nxt = ST_PLAY;
            ST_PLAY:  if (tick_en && (miss1 || miss2))        state_nxt = ST_POINT;
            ST_POINT: state_nxt = (score1 == MAXS || score2 == MAXS) ? ST_OVER : ST_SERVE;
            ST_OVER:  state_nxt = ST_OVER;
            default:  state_nxt = ST_SERVE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        state_dbg = state;
        game_over = (score1 == MAXS) || (score2 == MAXS);
    end

    // Datapath. Scores and pulses are registered on the scoring tick so the
    // pulse and the new score are both visible during the POINT cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_x    <= CX;
            ball_y    <= CY;
            score1    <= '0;
            score2    <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            dx        <= 1'b1;
            dy        <= 1'b1;
            serve_dy  <= 1'b1;
            serve_cnt <= '0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                ST_SERVE: begin
                    ball_x <= CX;
                    ball_y <= CY;
                    if (tick_en) begin
                        serve_cnt <= (serve_cnt == SERVE_LAST) ? '0 : serve_cnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (tick_en) begin
                        ball_y <= y_nxt;
                        dy     <= dy_nxt;
                        if (miss1) begin
                            score2   <= sat_inc(score2, MAXS);
                            point_p2 <= 1'b1;
                        end else if (miss2) begin
                            score1   <= sat_inc(score1, MAXS);
                            point_p1 <= 1'b1;
                        end else begin
                            ball_x <= x_nxt;
                            dx     <= dx_nxt;
                        end
                    end
                end
                ST_POINT: begin
                    ball_x    <= CX;
                    ball_y    <= CY;
                    // Left player scored means the right player conceded.
                    dx        <= point_p1;
                    // Each serve goes the opposite vertical way to the last.
                    dy        <= ~serve_dy;
                    serve_dy  <= ~serve_dy;
                    serve_cnt <= '0;
                end
                default: begin
                    ball_x <= CX;
                    ball_y <= CY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
module tb_pong_ball_engine;
    import pong_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        game_en;
    logic [9:0]  paddle1_y, paddle2_y;
    logic [9:0]  ball_x, ball_y;
    logic [3:0]  score1, score2;
    logic        point_p1, point_p2, game_over;
    ball_state_t state_dbg;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;
    int p1_cnt = 0;
    int p2_cnt = 0;
    int p1_base;

    pong_ball_engine #(
        .TICK_DIV    (4),
        .SERVE_TICKS (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .game_en   (game_en),
        .paddle1_y (paddle1_y),
        .paddle2_y (paddle2_y),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score1    (score1),
        .score2    (score2),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .game_over (game_over),
        .state_dbg (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // pulse counters, sampled just before each active edge
    always @(posedge clk) begin
        if (point_p1 === 1'b1) p1_cnt = p1_cnt + 1;
        if (point_p2 === 1'b1) p2_cnt = p2_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Run until the given count of active edges since reset release, then
    // settle on the following falling edge.
    task automatic advance_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n = edge_n + 1;
        end
        @(negedge clk);
    endtask

    task automatic chk_ball(input string tag, input int x, input int y);
        chk({tag, "_x"}, 32'(ball_x), x);
        chk({tag, "_y"}, 32'(ball_y), y);
    endtask

    initial begin
        // ---------------- reset ----------------
        reset_n   = 1'b0;
        game_en   = 1'b1;
        paddle1_y = 10'd300;
        paddle2_y = 10'd400;
        repeat (3) @(negedge clk);
        chk_ball("reset_ball", 316, 236);
        chk("reset_score1", 32'(score1), 0);
        chk("reset_score2", 32'(score2), 0);
        chk("reset_p1", 32'(point_p1), 0);
        chk("reset_p2", 32'(point_p2), 0);
        chk("reset_game_over", 32'(game_over), 0);
        chk("reset_state", 32'(state_dbg), 32'(ST_SERVE));
        reset_n = 1'b1;
        edge_n  = 0;

        // ---------------- serve delay and first move ----------------
        advance_to(12);
        chk_ball("serve_hold", 316, 236);
        chk("serve_state", 32'(state_dbg), 32'(ST_PLAY));
        advance_to(13);
        chk_ball("first_move", 318, 238);

        // ---------------- freeze for 50 cycles ----------------
        advance_to(14);
        game_en = 1'b0;
        advance_to(64);
        chk_ball("frozen", 318, 238);
        game_en = 1'b1;
        advance_to(66);
        chk_ball("resume_wait", 318, 238);
        advance_to(67);
        chk_ball("resume_move", 320, 240);

        // ---------------- bottom wall ----------------
        advance_to(527);
        chk("bottom_approach_y", 32'(ball_y), 470);
        advance_to(531);
        chk_ball("bottom_clamp", 552, 472);
        advance_to(535);
        chk("bottom_away_y", 32'(ball_y), 470);

        // ---------------- right paddle hit ----------------
        advance_to(627);
        chk_ball("rhit_before", 600, 424);
        advance_to(631);
        chk_ball("rhit", 602, 422);
        advance_to(635);
        chk_ball("rhit_after", 600, 420);

        // ---------------- top wall ----------------
        advance_to(1471);
        chk("top_approach_y", 32'(ball_y), 2);
        advance_to(1475);
        chk("top_clamp_y", 32'(ball_y), 0);
        advance_to(1479);
        chk("top_away_y", 32'(ball_y), 2);

        // ---------------- left paddle out of reach: pass, then miss ----------------
        advance_to(1775);
        chk("lpass_x", 32'(ball_x), 30);
        advance_to(1779);
        chk("lpass_next_x", 32'(ball_x), 28);
        advance_to(1834);
        chk("lmiss_pre_x", 32'(ball_x), 2);
        chk("lmiss_pre_p2", 32'(point_p2), 0);
        chk("lmiss_pre_state", 32'(state_dbg), 32'(ST_PLAY));
        advance_to(1835);
        chk("lmiss_p2", 32'(point_p2), 1);
        chk("lmiss_score2", 32'(score2), 1);
        chk("lmiss_score1", 32'(score1), 0);
        chk("lmiss_state", 32'(state_dbg), 32'(ST_POINT));
        paddle1_y = 10'd20;
        advance_to(1836);
        chk("lmiss_p2_end", 32'(point_p2), 0);
        chk("lmiss_p2_count", 32'(p2_cnt), 1);
        chk("lmiss_p1_count", 32'(p1_cnt), 0);
        chk("lmiss_state_next", 32'(state_dbg), 32'(ST_SERVE));
        chk_ball("lmiss_centre", 316, 236);

        // ---------------- second serve: toward left, upward ----------------
        advance_to(1847);
        chk_ball("serve2_move", 314, 234);

        // ---------------- left paddle hit ----------------
        advance_to(2411);
        chk_ball("lhit_before", 32, 48);
        advance_to(2415);
        chk_ball("lhit", 30, 50);
        advance_to(2419);
        chk_ball("lhit_after", 32, 52);
        chk("lhit_p2_count", 32'(p2_cnt), 1);

        // ---------------- asynchronous reset mid-play ----------------
        advance_to(2421);
        reset_n = 1'b0;
        #1;
        chk_ball("async_reset", 316, 236);
        chk("async_reset_score2", 32'(score2), 0);
        chk("async_reset_state", 32'(state_dbg), 32'(ST_SERVE));
        @(negedge clk);
        paddle2_y = 10'd200;
        reset_n   = 1'b1;
        edge_n    = 0;
        p1_base   = p1_cnt;

        // ---------------- repeated right misses to game over ----------------
        advance_to(641);
        chk("rmiss1_p1", 32'(point_p1), 1);
        chk("rmiss1_score1", 32'(score1), 1);
        chk("rmiss1_state", 32'(state_dbg), 32'(ST_POINT));
        chk("rmiss1_game_over", 32'(game_over), 0);
        advance_to(642);
        chk("rmiss1_p1_end", 32'(point_p1), 0);
        chk("rmiss1_state_next", 32'(state_dbg), 32'(ST_SERVE));
        advance_to(653);
        chk_ball("serve_r2_move", 318, 234);
        advance_to(5121);
        chk("rmiss8_score1", 32'(score1), 8);
        chk("rmiss8_game_over", 32'(game_over), 0);
        advance_to(5761);
        chk("rmiss9_p1", 32'(point_p1), 1);
        chk("rmiss9_score1", 32'(score1), 9);
        chk("rmiss9_game_over", 32'(game_over), 1);
        advance_to(5762);
        chk("over_state", 32'(state_dbg), 32'(ST_OVER));
        chk_ball("over_centre", 316, 236);
        advance_to(6162);
        chk("over_hold_state", 32'(state_dbg), 32'(ST_OVER));
        chk_ball("over_hold_centre", 316, 236);
        chk("over_hold_score1", 32'(score1), 9);
        chk("over_hold_score2", 32'(score2), 0);
        chk("over_hold_game_over", 32'(game_over), 1);
        chk("over_p1_pulses", 32'(p1_cnt - p1_base), 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
